// File: rtl/taxi_xmii_rx_gearbox.sv
// RMII/MII receive gearbox: hunts the SFD and packs symbols into byte-lane words.
// Define TAXI_XMII_RX_STAT_EN to enable the frame/bad-frame counters.
module taxi_xmii_rx_gearbox #(
  parameter int IN_W   = 4,
  parameter int OUT_W  = 8,
  parameter int KEEP_W = OUT_W/8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_ce,
  input  logic [IN_W-1:0]   in_d,
  input  logic              in_dv,
  input  logic              in_er,
  output logic [OUT_W-1:0]  out_d,
  output logic [KEEP_W-1:0] out_keep,
  output logic              out_valid,
  output logic              out_start,
  output logic              out_last,
  output logic              out_er,
  output logic              status_dribble,
  output logic              status_align_err,
  output logic [15:0]       stat_frames,
  output logic [15:0]       stat_bad
);

  localparam int SPW = 8/IN_W;
  localparam int SCW = $clog2(SPW);
  localparam int LW  = KEEP_W > 1 ? $clog2(KEEP_W) : 1;

  typedef enum logic [1:0] {
    IDLE, PRE, DATA, DRAIN
  } state_t;

  state_t             state_q;
  logic [7:0]         win_q;
  logic [SCW-1:0]     sym_cnt_q;
  logic [LW-1:0]      lane_q;
  logic [7:0]         byte_q;
  logic [OUT_W-1:0]   word_q;
  logic [OUT_W-1:0]   hold_q;
  logic               held_q;
  logic               err_q;
  logic               started_q;

  logic [OUT_W-1:0]   out_d_q;
  logic [KEEP_W-1:0]  out_keep_q;
  logic               out_valid_q;
  logic               out_start_q;
  logic               out_last_q;
  logic               out_er_q;
  logic               dribble_q;
  logic               align_q;

  logic [7:0]         win_d;
  logic [7:0]         byte_d;
  logic [OUT_W-1:0]   word_d;
  logic [KEEP_W-1:0]  keep_part;
  logic               byte_done;
  logic               word_done;
  logic               err_end;

  logic               em_valid;
  logic [OUT_W-1:0]   em_d;
  logic [KEEP_W-1:0]  em_keep;
  logic               em_last;
  logic               em_err;

  assign win_d     = (win_q >> IN_W) | (8'(in_d) << (8 - IN_W));
  assign byte_done = sym_cnt_q == SCW'(SPW - 1);
  assign word_done = byte_done && lane_q == LW'(KEEP_W - 1);
  assign err_end   = err_q | (sym_cnt_q != '0);

  always_comb begin
    byte_d = byte_q;
    byte_d[sym_cnt_q*IN_W +: IN_W] = in_d;
    word_d = word_q;
    word_d[lane_q*8 +: 8] = byte_d;
    for (int i = 0; i < KEEP_W; i++) begin
      keep_part[i] = LW'(i) < lane_q;
    end
  end

  // Word leaving the gearbox this cycle; registered below.
  always_comb begin
    em_valid = 1'b0;
    em_d     = hold_q;
    em_keep  = '1;
    em_last  = 1'b0;
    em_err   = 1'b0;
    unique case (state_q)
      DATA: begin
        if (in_ce) begin
          if (in_dv) begin
            em_valid = word_done && held_q;
          end else if (lane_q != '0) begin
            em_valid = 1'b1;
            if (!held_q) begin
              em_d    = word_q;
              em_keep = keep_part;
              em_last = 1'b1;
              em_err  = err_end;
            end
          end else if (held_q) begin
            em_valid = 1'b1;
            em_last  = 1'b1;
            em_err   = err_end;
          end
        end
      end
      DRAIN: begin
        em_valid = 1'b1;
        em_d     = word_q;
        em_keep  = keep_part;
        em_last  = 1'b1;
        em_err   = err_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      win_q       <= '0;
      sym_cnt_q   <= '0;
      lane_q      <= '0;
      byte_q      <= '0;
      word_q      <= '0;
      hold_q      <= '0;
      held_q      <= 1'b0;
      err_q       <= 1'b0;
      started_q   <= 1'b0;
      out_d_q     <= '0;
      out_keep_q  <= '0;
      out_valid_q <= 1'b0;
      out_start_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_er_q    <= 1'b0;
      dribble_q   <= 1'b0;
      align_q     <= 1'b0;
    end else begin
      out_valid_q <= em_valid;
      out_start_q <= em_valid && !started_q;
      out_last_q  <= em_last;
      out_er_q    <= em_err;
      dribble_q   <= 1'b0;
      align_q     <= 1'b0;
      if (em_valid) begin
        out_d_q    <= em_d;
        out_keep_q <= em_keep;
        started_q  <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (in_ce && in_dv) begin
            win_q   <= win_d;
            state_q <= PRE;
          end
        end
        PRE: begin
          if (in_ce) begin
            if (!in_dv) begin
              align_q <= 1'b1;
              win_q   <= '0;
              state_q <= IDLE;
            end else if (win_d == 8'hD5) begin
              win_q     <= '0;
              sym_cnt_q <= '0;
              lane_q    <= '0;
              byte_q    <= '0;
              word_q    <= '0;
              held_q    <= 1'b0;
              err_q     <= 1'b0;
              started_q <= 1'b0;
              state_q   <= DATA;
            end else begin
              win_q <= win_d;
            end
          end
        end
        DATA: begin
          if (in_ce && in_dv) begin
            err_q <= err_q | in_er;
            if (!byte_done) begin
              sym_cnt_q <= sym_cnt_q + 1'b1;
              byte_q    <= byte_d;
            end else begin
              sym_cnt_q <= '0;
              byte_q    <= '0;
              if (word_done) begin
                lane_q <= '0;
                word_q <= '0;
                hold_q <= word_d;
                held_q <= 1'b1;
              end else begin
                lane_q <= lane_q + 1'b1;
                word_q <= word_d;
              end
            end
          end else if (in_ce) begin
            // Partial byte is dropped; the frame is then marked bad.
            dribble_q <= sym_cnt_q != '0;
            err_q     <= err_end;
            state_q   <= (lane_q != '0 && held_q) ? DRAIN : IDLE;
          end
        end
        DRAIN: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_d            = out_d_q;
  assign out_keep         = out_keep_q;
  assign out_valid        = out_valid_q;
  assign out_start        = out_start_q;
  assign out_last         = out_last_q;
  assign out_er           = out_er_q;
  assign status_dribble   = dribble_q;
  assign status_align_err = align_q;

`ifdef TAXI_XMII_RX_STAT_EN
  logic [15:0] frames_q;
  logic [15:0] bad_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frames_q <= '0;
      bad_q    <= '0;
    end else if (em_valid && em_last) begin
      if (frames_q != 16'hFFFF) frames_q <= frames_q + 1'b1;
      if (em_err && bad_q != 16'hFFFF) bad_q <= bad_q + 1'b1;
    end
  end

  assign stat_frames = frames_q;
  assign stat_bad    = bad_q;
`else
  assign stat_frames = '0;
  assign stat_bad    = '0;
`endif

endmodule

// File: tb/tb_taxi_xmii_rx_gearbox.sv
// Bench for taxi_xmii_rx_gearbox: three configurations, table of frames,
// expected words queued at stimulus time and popped by an output monitor.
module tb_taxi_xmii_rx_gearbox;

  typedef struct packed {
    logic [1:0]  k;
    logic [63:0] d;
    logic [7:0]  keep;
    logic        s;
    logic        l;
    logic        e;
  } exp_t;

  typedef struct packed {
    logic [1:0]  k;
    logic [3:0]  nb;
    logic [63:0] b;
    logic [3:0]  erb;
    logic        extra;
    logic [3:0]  div;
    logic        drib;
    logic        bad;
  } frame_t;

  logic clk = 1'b0;
  logic rst;
  logic ce [3];
  logic dv [3];
  logic er [3];
  logic [3:0] d0, d1;
  logic [1:0] d2;

  logic [7:0]  o0_d;
  logic [0:0]  o0_k;
  logic        o0_v, o0_s, o0_l, o0_e, o0_dr, o0_al;
  logic [15:0] o0_sf, o0_sb;
  logic [31:0] o1_d;
  logic [3:0]  o1_k;
  logic        o1_v, o1_s, o1_l, o1_e, o1_dr, o1_al;
  logic [15:0] o1_sf, o1_sb;
  logic [15:0] o2_d;
  logic [1:0]  o2_k;
  logic        o2_v, o2_s, o2_l, o2_e, o2_dr, o2_al;
  logic [15:0] o2_sf, o2_sb;

  exp_t expq [$];
  int n_chk = 0;
  int n_fail = 0;
  int drib_cnt [3] = '{0, 0, 0};
  int align_cnt [3] = '{0, 0, 0};
  int exp_frames [3] = '{0, 0, 0};
  int exp_bad [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  taxi_xmii_rx_gearbox #(.IN_W(4), .OUT_W(8)) u0 (
    .clk(clk), .rst(rst), .in_ce(ce[0]), .in_d(d0), .in_dv(dv[0]),
    .in_er(er[0]), .out_d(o0_d), .out_keep(o0_k), .out_valid(o0_v),
    .out_start(o0_s), .out_last(o0_l), .out_er(o0_e),
    .status_dribble(o0_dr), .status_align_err(o0_al),
    .stat_frames(o0_sf), .stat_bad(o0_sb));

  taxi_xmii_rx_gearbox #(.IN_W(4), .OUT_W(32)) u1 (
    .clk(clk), .rst(rst), .in_ce(ce[1]), .in_d(d1), .in_dv(dv[1]),
    .in_er(er[1]), .out_d(o1_d), .out_keep(o1_k), .out_valid(o1_v),
    .out_start(o1_s), .out_last(o1_l), .out_er(o1_e),
    .status_dribble(o1_dr), .status_align_err(o1_al),
    .stat_frames(o1_sf), .stat_bad(o1_sb));

  taxi_xmii_rx_gearbox #(.IN_W(2), .OUT_W(16)) u2 (
    .clk(clk), .rst(rst), .in_ce(ce[2]), .in_d(d2), .in_dv(dv[2]),
    .in_er(er[2]), .out_d(o2_d), .out_keep(o2_k), .out_valid(o2_v),
    .out_start(o2_s), .out_last(o2_l), .out_er(o2_e),
    .status_dribble(o2_dr), .status_align_err(o2_al),
    .stat_frames(o2_sf), .stat_bad(o2_sb));

  task automatic chk(string nm, logic [63:0] got, logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic check_out(int k, logic [63:0] d, logic [7:0] kp,
                           logic s, logic l, logic e);
    exp_t x;
    n_chk++;
    if (expq.size() == 0) begin
      n_fail++;
      $display("FAIL out_unexpected inst=%0d got d=%0h keep=%0h", k, d, kp);
    end else begin
      x = expq.pop_front();
      if (x.k != 2'(k) || x.d != d || x.keep != kp ||
          x.s != s || x.l != l || x.e != e) begin
        n_fail++;
        $display("FAIL out_word inst=%0d got d=%0h k=%0h s%0b l%0b e%0b want inst=%0d d=%0h k=%0h s%0b l%0b e%0b",
                 k, d, kp, s, l, e, x.k, x.d, x.keep, x.s, x.l, x.e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (o0_v) check_out(0, 64'(o0_d), 8'(o0_k), o0_s, o0_l, o0_e);
    if (o1_v) check_out(1, 64'(o1_d), 8'(o1_k), o1_s, o1_l, o1_e);
    if (o2_v) check_out(2, 64'(o2_d), 8'(o2_k), o2_s, o2_l, o2_e);
    if (o0_dr) drib_cnt[0] += 1;
    if (o1_dr) drib_cnt[1] += 1;
    if (o2_dr) drib_cnt[2] += 1;
    if (o0_al) align_cnt[0] += 1;
    if (o1_al) align_cnt[1] += 1;
    if (o2_al) align_cnt[2] += 1;
  end

  function automatic logic outs_zero(int k);
    case (k)
      0: return ~|{o0_d, o0_k, o0_v, o0_s, o0_l, o0_e, o0_dr, o0_al, o0_sf, o0_sb};
      1: return ~|{o1_d, o1_k, o1_v, o1_s, o1_l, o1_e, o1_dr, o1_al, o1_sf, o1_sb};
      default: return ~|{o2_d, o2_k, o2_v, o2_s, o2_l, o2_e, o2_dr, o2_al, o2_sf, o2_sb};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sym(int k, logic [3:0] s, logic v, logic e, int div);
    case (k)
      0: d0 = s;
      1: d1 = s;
      default: d2 = s[1:0];
    endcase
    ce[k] = 1'b1;
    dv[k] = v;
    er[k] = e;
    tick();
    ce[k] = 1'b0;
    repeat (div - 1) tick();
  endtask

  task automatic send_byte(int k, logic [7:0] by, logic e, int div);
    int iw;
    iw = (k == 2) ? 2 : 4;
    for (int s = 0; s < 8 / iw; s++)
      sym(k, 4'(by >> (s * iw)), 1'b1, e && s == 0, div);
  endtask

  task automatic send_pre(int k, int div);
    for (int i = 0; i < 7; i++) send_byte(k, 8'h55, 1'b0, div);
    send_byte(k, 8'hD5, 1'b0, div);
  endtask

  task automatic push_exp(int k, int nb, logic [63:0] b, logic err);
    exp_t x;
    logic [63:0] w;
    int kw, ln;
    logic first;
    kw = (k == 0) ? 1 : (k == 1) ? 4 : 2;
    w = '0;
    ln = 0;
    first = 1'b1;
    for (int i = 0; i < nb; i++) begin
      w[ln*8 +: 8] = b[i*8 +: 8];
      ln++;
      if (ln == kw || i == nb - 1) begin
        x.k = 2'(k);
        x.d = w;
        x.keep = 8'((1 << ln) - 1);
        x.s = first;
        x.l = (i == nb - 1);
        x.e = x.l && err;
        expq.push_back(x);
        first = 1'b0;
        w = '0;
        ln = 0;
      end
    end
    if (nb > 0) begin
      exp_frames[k]++;
      if (err) exp_bad[k]++;
    end
  endtask

  task automatic chk_stats(int k);
    logic [15:0] f, b;
    case (k)
      0: begin f = o0_sf; b = o0_sb; end
      1: begin f = o1_sf; b = o1_sb; end
      default: begin f = o2_sf; b = o2_sb; end
    endcase
`ifdef TAXI_XMII_RX_STAT_EN
    chk("stat_frames", 64'(f), 64'(exp_frames[k]));
    chk("stat_bad", 64'(b), 64'(exp_bad[k]));
`else
    chk("stat_frames_tied", 64'(f), 64'd0);
    chk("stat_bad_tied", 64'(b), 64'd0);
`endif
  endtask

  task automatic run_rec(frame_t r);
    int k, db, ab;
    k = int'(r.k);
    db = drib_cnt[k];
    ab = align_cnt[k];
    push_exp(k, int'(r.nb), r.b, r.bad);
    send_pre(k, int'(r.div));
    for (int i = 0; i < int'(r.nb); i++)
      send_byte(k, r.b[i*8 +: 8], i == int'(r.erb), int'(r.div));
    if (r.extra) sym(k, 4'h1, 1'b1, 1'b0, int'(r.div));
    sym(k, 4'h0, 1'b0, 1'b0, int'(r.div));
    repeat (4) tick();
    chk("queue_drained", 64'(expq.size()), 64'd0);
    chk("dribble_pulses", 64'(drib_cnt[k] - db), 64'(r.drib));
    chk("align_pulses", 64'(align_cnt[k] - ab), 64'd0);
    chk_stats(k);
  endtask

  frame_t tbl [9];

  initial begin
    int ab;
    tbl[0] = '{2'd0, 4'd3, 64'h030201,           4'hF, 1'b0, 4'd1,  1'b0, 1'b0};
    tbl[1] = '{2'd1, 4'd5, 64'h1514131211,       4'hF, 1'b0, 4'd1,  1'b0, 1'b0};
    tbl[2] = '{2'd2, 4'd3, 64'hCCBBAA,           4'hF, 1'b1, 4'd1,  1'b1, 1'b1};
    tbl[3] = '{2'd0, 4'd3, 64'h030201,           4'd1, 1'b0, 4'd10, 1'b0, 1'b1};
    tbl[4] = '{2'd1, 4'd8, 64'h8877665544332211, 4'hF, 1'b0, 4'd1,  1'b0, 1'b0};
    tbl[5] = '{2'd1, 4'd3, 64'h0C0B0A,           4'hF, 1'b0, 4'd2,  1'b0, 1'b0};
    tbl[6] = '{2'd2, 4'd0, 64'h0,                4'hF, 1'b0, 4'd1,  1'b0, 1'b0};
    tbl[7] = '{2'd2, 4'd4, 64'h44332211,         4'd3, 1'b0, 4'd3,  1'b0, 1'b1};
    tbl[8] = '{2'd1, 4'd1, 64'h5A,               4'hF, 1'b1, 4'd1,  1'b1, 1'b1};

    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ce[k] = 1'b0;
      dv[k] = 1'b0;
      er[k] = 1'b0;
    end
    d0 = '0;
    d1 = '0;
    d2 = '0;
    repeat (2) tick();
    for (int k = 0; k < 3; k++) chk("reset_outputs_zero", 64'(outs_zero(k)), 64'd1);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) run_rec(tbl[i]);

    // Carrier drops after four preamble nibbles.
    ab = align_cnt[0];
    for (int i = 0; i < 4; i++) sym(0, 4'h5, 1'b1, 1'b0, 1);
    sym(0, 4'h0, 1'b0, 1'b0, 1);
    repeat (3) tick();
    chk("align_err_pulse", 64'(align_cnt[0] - ab), 64'd1);
    chk("align_no_output", 64'(expq.size()), 64'd0);

    // Reset mid-DATA: first word already out, frame then abandoned.
    push_exp(0, 1, 64'h01, 1'b0);
    expq[expq.size() - 1].l = 1'b0;
    send_pre(0, 1);
    send_byte(0, 8'h01, 1'b0, 1);
    send_byte(0, 8'h02, 1'b0, 1);
    sym(0, 4'h3, 1'b1, 1'b0, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_frame_zero", 64'(outs_zero(0)), 64'd1);
    chk("rst_first_word_seen", 64'(expq.size()), 64'd0);
    ce[0] = 1'b0;
    dv[0] = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_frames[k] = 0;
      exp_bad[k] = 0;
    end
    tick();
    run_rec('{2'd0, 4'd2, 64'h0B0A, 4'hF, 1'b0, 4'd1, 1'b0, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
